// File: rtl/div_5_pkg.sv
// Shared definitions for the serial divisibility-by-5 detector: divisor,
// remainder state encoding and the remainder transition function.
package div_5_pkg;

    localparam int unsigned DIVISOR = 5;

    typedef enum logic [2:0] {
        REM0 = 3'd0,
        REM1 = 3'd1,
        REM2 = 3'd2,
        REM3 = 3'd3,
        REM4 = 3'd4
    } rem_t;

    // Appending a bit MSB-first doubles the value and adds the bit, so the
    // new remainder is (2*rem + in_bit) mod DIVISOR.
    function automatic rem_t next_rem(input rem_t rem, input logic in_bit);
        rem_t result;
        result = REM0;
        case (rem)
            REM0:    result = in_bit ? REM1 : REM0;
            REM1:    result = in_bit ? REM3 : REM2;
            REM2:    result = in_bit ? REM0 : REM4;
            REM3:    result = in_bit ? REM2 : REM1;
            REM4:    result = in_bit ? REM4 : REM3;
            default: result = REM0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/div_5_detector.sv
// Serial divisibility-by-5 detector: tracks the remainder of an MSB-first
// bit stream and flags nonzero values that are multiples of DIVISOR.
module div_5_detector
    import div_5_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_bit,
    output logic div_5
);

    rem_t rem;
    rem_t w_rem_next;
    logic first_1_seen;
    logic w_first_1_seen_next;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem          <= REM0;
            first_1_seen <= 1'b0;
        end else begin
            rem          <= w_rem_next;
            first_1_seen <= w_first_1_seen_next;
        end
    end

    // NOTE: every combinational output is assigned on all paths (here
    // unconditionally), so no latch can be inferred.
    always_comb begin
        w_rem_next          = next_rem(rem, in_bit);
        w_first_1_seen_next = first_1_seen | in_bit;
        // Registered-only decode: a value of zero is never reported.
        div_5               = first_1_seen && (rem == REM0);
    end

endmodule

// File: tb/tb_div_5_detector.sv
// Directed and model-based bench for div_5_detector.
module tb_div_5_detector;

    logic clk;
    logic rst_n;
    logic in_bit;
    logic div_5;

    int n_checks;
    int n_errors;

    div_5_detector dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_bit (in_bit),
        .div_5  (div_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Present one bit, let it be sampled, then check div_5 1ns after the edge.
    task automatic step(input logic b, input logic exp, input string tag);
        in_bit = b;
        @(posedge clk);
        #1;
        check(tag, {31'd0, div_5}, {31'd0, exp});
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    int   model_r;
    logic model_seen;
    logic rb;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_bit   = 1'b0;

        // Reset held for 5 cycles with in_bit toggling.
        for (int i = 0; i < 5; i++) begin
            in_bit = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("rst_div5", {31'd0, div_5}, 32'd0);
            check("rst_seen", {31'd0, dut.first_1_seen}, 32'd0);
            check("rst_rem", {29'd0, dut.rem}, 32'd0);
        end
        rst_n = 1'b1;

        // 1,0,1 = 5; then 0 = 10; then 1 = 21.
        step(1'b1, 1'b0, "s5_v1");
        step(1'b0, 1'b0, "s5_v2");
        step(1'b1, 1'b1, "s5_v5");
        step(1'b0, 1'b1, "s5_v10");
        step(1'b1, 1'b0, "s5_v21");

        // Leading zeros, then 1,0,1 = 5.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, "lz_div5");
            check("lz_seen", {31'd0, dut.first_1_seen}, 32'd0);
        end
        step(1'b1, 1'b0, "lz_v1");
        check("lz_seen_set", {31'd0, dut.first_1_seen}, 32'd1);
        step(1'b0, 1'b0, "lz_v2");
        step(1'b1, 1'b1, "lz_v5");

        // 1,1,1,1 = 1,3,7,15; then 0,0 = 30,60.
        pulse_reset();
        step(1'b1, 1'b0, "ones_v1");
        step(1'b1, 1'b0, "ones_v3");
        step(1'b1, 1'b0, "ones_v7");
        step(1'b1, 1'b1, "ones_v15");
        step(1'b0, 1'b1, "ones_v30");
        step(1'b0, 1'b1, "ones_v60");

        // Asynchronous reset mid-stream clears the flag before any edge.
        pulse_reset();
        step(1'b1, 1'b0, "ar_v1");
        step(1'b0, 1'b0, "ar_v2");
        step(1'b1, 1'b1, "ar_v5");
        rst_n = 1'b0;
        #1;
        check("ar_async_div5", {31'd0, div_5}, 32'd0);
        check("ar_async_seen", {31'd0, dut.first_1_seen}, 32'd0);
        check("ar_async_rem", {29'd0, dut.rem}, 32'd0);
        #2;
        rst_n = 1'b1;
        step(1'b1, 1'b0, "ar_new_v1");
        step(1'b1, 1'b0, "ar_new_v3");

        // 200 random bits against a reference remainder model.
        pulse_reset();
        model_r    = 0;
        model_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rb         = 1'($urandom_range(0, 1));
            model_r    = (2 * model_r + int'(rb)) % 5;
            model_seen = model_seen | rb;
            step(rb, model_seen && (model_r == 0), "rand_div5");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
